// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor: default operand/digit widths,
// the controller state encoding and a counter-width helper.
package serial_sub_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGIT  = 4;
    localparam int DEF_DIGITS = DEF_WIDTH / DEF_DIGIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operation bus of the serial subtractor. The master (controller) raises start
// with operands A/B; the request is taken on any rising edge where ready=1.
// done pulses for one cycle when Diff/BO (and OV when SUB_OVERFLOW_EN is
// defined) hold a new result; those outputs stay stable until the next one.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             BO;
`ifdef SUB_OVERFLOW_EN
    logic             OV;

    modport master (output start, A, B, input ready, done, Diff, BO, OV);
    modport slave  (input start, A, B, output ready, done, Diff, BO, OV);
`else
    modport master (output start, A, B, input ready, done, Diff, BO);
    modport slave  (input start, A, B, output ready, done, Diff, BO);
`endif

endinterface

// File: rtl/serial_subtractor_digit_adder.sv
// One-digit ripple-carry adder used as the datapath slice of the serial
// subtractor: sum_o/cout_o = a_i + b_i + cin_i.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o
);

    logic [DIGIT:0] carry;

    // Ripple the carry through each bit of the digit.
    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < DIGIT; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[DIGIT];
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: Diff = A - B computed as A + ~B + 1, one DIGIT-wide
// slice per clock, least significant digit first.
// Optional feature macro: SUB_OVERFLOW_EN adds the signed-overflow output OV.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic                Clk,
    input  logic                Reset,
    serial_subtractor_if.slave  sub_if,
    output state_t              dbg_state_o
);

    localparam int            N    = WIDTH / DIGIT;
    localparam int            CW   = cnt_width(N);
    localparam int            RW   = WIDTH - DIGIT;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q, bo_d;
`ifdef SUB_OVERFLOW_EN
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic             ov_q, ov_d;
`endif

    logic [DIGIT-1:0] sum;
    logic             cout;
    logic             ready;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a_i    (a_q[DIGIT-1:0]),
        .b_i    (nb_q[DIGIT-1:0]),
        .cin_i  (carry_q),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // A new operation can be taken both when idle and in the result cycle.
    assign ready = (state_q == IDLE) || (state_q == DONE);

    // Next-state and datapath update; result registers move only when the last digit lands.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nb_d    = nb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bo_d    = bo_q;
`ifdef SUB_OVERFLOW_EN
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        ov_d     = ov_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (sub_if.start) begin
                    a_d     = sub_if.A;
                    nb_d    = ~sub_if.B;
                    carry_d = 1'b1;
                    cnt_d   = '0;
`ifdef SUB_OVERFLOW_EN
                    a_sign_d = sub_if.A[WIDTH-1];
                    b_sign_d = sub_if.B[WIDTH-1];
`endif
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                nb_d    = nb_q >> DIGIT;
                carry_d = cout;
                res_d   = RW'({sum, res_q} >> DIGIT);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = {sum, res_q};
                    bo_d    = ~cout;
                    cnt_d   = '0;
`ifdef SUB_OVERFLOW_EN
                    ov_d = (a_sign_q != b_sign_q) && (sum[DIGIT-1] != a_sign_q);
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Operand shifters, carry, digit counter and result registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_q     <= '0;
            nb_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ov_q     <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            nb_q    <= nb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
`ifdef SUB_OVERFLOW_EN
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            ov_q     <= ov_d;
`endif
        end
    end

    assign sub_if.ready = ready;
    assign sub_if.done  = (state_q == DONE);
    assign sub_if.Diff  = diff_q;
    assign sub_if.BO    = bo_q;
`ifdef SUB_OVERFLOW_EN
    assign sub_if.OV    = ov_q;
`endif
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (optionally with SUB_OVERFLOW_EN).
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int NC = DEF_DIGITS;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();
    state_t dbg_state;

    serial_subtractor #(.WIDTH(W), .DIGIT(DEF_DIGIT)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .sub_if      (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Entry layout: {ov, bo, diff}
    logic [W+1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        d  = a - b;
        bo = (a < b);
        ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        return {ov, bo, d};
    endfunction

    function automatic logic obs_ov();
`ifdef SUB_OVERFLOW_EN
        return bus.OV;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge: presents one request, leaves at the negedge after acceptance.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        exp_q.push_back(model(a, b));
        @(negedge Clk);
        bus.start = 1'b0;
    endtask

    // Counts rising edges until done is seen, bounded.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 4 * NC + 8; i++) begin
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.Diff !== '0 || bus.BO !== 1'b0 ||
            obs_ov() !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b done=%b diff=%h bo=%b ov=%b state=%0d want 1 0 0000 0 0 0",
                     bus.ready, bus.done, bus.Diff, bus.BO, obs_ov(), dbg_state);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] va[10];
        logic [W-1:0] vb[10];
        logic [W+1:0] exp;
        int lat;
        bit ok;
        va[0] = 16'h4444; vb[0] = 16'h3333;
        va[1] = 16'h2222; vb[1] = 16'h3333;
        va[2] = 16'h8000; vb[2] = 16'h0001;
        va[3] = 16'hFFFF; vb[3] = 16'hFFFF;
        va[4] = 16'h7FFF; vb[4] = 16'hFFFF;
        va[5] = 16'h0000; vb[5] = 16'h0001;
        for (int i = 6; i < 10; i++) begin
            va[i] = W'($urandom_range(0, 16'hFFFF));
            vb[i] = W'($urandom_range(0, 16'hFFFF));
        end
        for (int i = 0; i < 10; i++) begin
            issue(va[i], vb[i]);
            checks++;
            if (bus.ready !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy[%0d] got ready=%b want 0", i, bus.ready);
            end
            wait_done(lat, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL basic_timeout[%0d] got no done want done within budget", i);
                continue;
            end
            if (lat != NC) begin
                errors++;
                $display("FAIL basic_latency[%0d] got %0d want %0d", i, lat, NC);
            end
            checks++;
            if (bus.Diff !== exp[W-1:0] || bus.BO !== exp[W]) begin
                errors++;
                $display("FAIL basic_result[%0d] A=%h B=%h got diff=%h bo=%b want diff=%h bo=%b",
                         i, va[i], vb[i], bus.Diff, bus.BO, exp[W-1:0], exp[W]);
            end
`ifdef SUB_OVERFLOW_EN
            checks++;
            if (bus.OV !== exp[W+1]) begin
                errors++;
                $display("FAIL basic_ov[%0d] A=%h B=%h got %b want %b", i, va[i], vb[i], bus.OV, exp[W+1]);
            end
`endif
            @(negedge Clk);
            checks++;
            if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.Diff !== exp[W-1:0] || bus.BO !== exp[W]) begin
                errors++;
                $display("FAIL basic_after_done[%0d] got done=%b ready=%b diff=%h bo=%b want 0 1 %h %b",
                         i, bus.done, bus.ready, bus.Diff, bus.BO, exp[W-1:0], exp[W]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] exp;
        int gap;
        int ops;
        bit seen_first;
        bus.start = 1'b1;
        bus.A     = 16'h0005;
        bus.B     = 16'h0003;
        exp_q.push_back(model(16'h0005, 16'h0003));
        ops = 0;
        gap = 0;
        seen_first = 1'b0;
        for (int cyc = 0; cyc < 60 && ops < 4; cyc++) begin
            @(negedge Clk);
            gap++;
            if (bus.done === 1'b1) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                checks++;
                if (bus.Diff !== exp[W-1:0] || bus.BO !== exp[W] || bus.Diff !== 16'h0002) begin
                    errors++;
                    $display("FAIL b2b_result[%0d] got diff=%h bo=%b want diff=0002 bo=0", ops, bus.Diff, bus.BO);
                end
                if (seen_first) begin
                    checks++;
                    if (gap != NC + 1) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d] got %0d cycles want %0d", ops, gap, NC + 1);
                    end
                end
                seen_first = 1'b1;
                gap = 0;
                ops++;
                if (ops < 4) begin
                    bus.A = 16'h0005;
                    bus.B = 16'h0003;
                    exp_q.push_back(model(16'h0005, 16'h0003));
                end else begin
                    bus.start = 1'b0;
                end
            end else begin
                // Scramble operands while the operation is in flight.
                bus.A = W'($urandom_range(0, 16'hFFFF));
                bus.B = W'($urandom_range(0, 16'hFFFF));
            end
        end
        bus.start = 1'b0;
        checks++;
        if (ops != 4) begin
            errors++;
            $display("FAIL b2b_count got %0d results want 4", ops);
        end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_run();
        logic [W+1:0] exp;
        logic [W+1:0] dropped;
        int lat;
        bit ok;
        bit saw_done;
        issue(16'hABCD, 16'h0123);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.Diff !== '0 || bus.BO !== 1'b0 ||
            obs_ov() !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL midrun_reset got ready=%b done=%b diff=%h bo=%b ov=%b state=%0d want 1 0 0000 0 0 0",
                     bus.ready, bus.done, bus.Diff, bus.BO, obs_ov(), dbg_state);
        end
        dropped = exp_q.pop_front();
        @(negedge Clk);
        Reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 2 * NC + 2; i++) begin
            @(negedge Clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midrun_no_done got done pulse want none (discarded %h)", dropped[W-1:0]);
        end
        issue(16'h1234, 16'h0234);
        wait_done(lat, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || lat != NC) begin
            errors++;
            $display("FAIL midrun_next_latency got ok=%0d lat=%0d want ok=1 lat=%0d", ok, lat, NC);
        end
        checks++;
        if (bus.Diff !== 16'h1000 || bus.Diff !== exp[W-1:0] || bus.BO !== 1'b0) begin
            errors++;
            $display("FAIL midrun_next_result got diff=%h bo=%b want diff=1000 bo=0", bus.Diff, bus.BO);
        end
        @(negedge Clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
